// File: rtl/apb_uart_pkg.sv
// Shared types for the APB UART completer: register word indices,
// transfer FSM states and the CTRL register layout.
package apb_uart_pkg;

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_SCRATCH = 3'd1;
  localparam logic [2:0] IDX_STATUS  = 3'd2;
  localparam logic [2:0] IDX_TXDATA  = 3'd3;
  localparam logic [2:0] IDX_LEVEL   = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  typedef struct packed {
    logic       ie;
    logic [3:0] wait_cnt;
  } ctrl_t;

  function automatic logic [31:0] strb_merge(
    input logic [31:0] old,
    input logic [31:0] nxt,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = strb[i] ? nxt[i*8 +: 8] : old[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/apb_uart_txfifo.sv
// Synchronous byte FIFO for the TX path; DEPTH must be a power of two.
// A push while full is accepted only when a pop happens in the same cycle.
module apb_uart_txfifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               din,
  input  logic                     pop,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PONE = 1;
  localparam logic [AW:0] LONE = 1;
  localparam logic [AW:0] LFULL = DEPTH;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          wr_en, rd_en;

  assign full  = level == LFULL;
  assign empty = level == '0;
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign dout  = empty ? 8'h00 : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PONE;
      if (rd_en) rptr <= rptr + PONE;
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + LONE;
        2'b01:   level <= level - LONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/apb_uart_completer.sv
// APB completer with CTRL/SCRATCH/STATUS/TXDATA/LEVEL registers and a TX FIFO.
// Define APB_PSTRB_EN to add the PSTRB byte-lane write strobes.
module apb_uart_completer
  import apb_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          RST_WAIT    = 0,
  parameter logic [31:0] SCRATCH_RST = 32'h0000_0000
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
`ifdef APB_PSTRB_EN
  input  logic [3:0]  PSTRB,
`endif
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam ctrl_t CTRL_RST = '{ie: 1'b0, wait_cnt: 4'(RST_WAIT)};

  state_t      state, state_nx;
  ctrl_t       ctrl_q;
  logic [31:0] addr_q, wdata_q, scratch_q;
  logic [31:0] rdata, lvl32, merged;
  logic [15:0] wr_cnt, rd_cnt;
  logic [3:0]  strb_q, cnt_q;
  logic [2:0]  idx;
  logic        write_q, load, active, step, done, err, commit;
  logic        bad_addr, hit_ctrl, hit_scr, hit_stat, hit_tx, hit_lvl;
  logic        push, pop, full, empty;
  logic [AW:0] level;

  assign load   = PSEL && !PENABLE;
  assign active = state != IDLE;
  assign step   = active && PSEL && PENABLE;
  assign done   = step && cnt_q == 4'd0;
  assign commit = done && !err;

  assign idx      = addr_q[4:2];
  assign bad_addr = (addr_q[31:5] != '0) || (addr_q[1:0] != 2'b00)
                 || (idx > IDX_LEVEL);
  assign hit_ctrl = !bad_addr && idx == IDX_CTRL;
  assign hit_scr  = !bad_addr && idx == IDX_SCRATCH;
  assign hit_stat = !bad_addr && idx == IDX_STATUS;
  assign hit_tx   = !bad_addr && idx == IDX_TXDATA;
  assign hit_lvl  = !bad_addr && idx == IDX_LEVEL;

  assign pop      = tx_valid && tx_ready;
  assign push     = commit && write_q && hit_tx;
  assign tx_valid = !empty;

  assign PREADY  = done;
  assign PSLVERR = done && err;
  assign PRDATA  = (done && !write_q && !err) ? rdata : '0;

  always_comb begin
    lvl32 = '0;
    lvl32[AW:0] = level;
  end

  always_comb begin
    merged = strb_merge(hit_ctrl ? {27'b0, ctrl_q} : scratch_q,
                        wdata_q, strb_q);
  end

  // A full FIFO still takes the push if the head leaves in the same cycle.
  always_comb begin
    rdata = '0;
    err   = 1'b0;
    unique case (1'b1)
      bad_addr: err = 1'b1;
      hit_ctrl: rdata = {27'b0, ctrl_q};
      hit_scr:  rdata = scratch_q;
      hit_stat: begin
        rdata = {rd_cnt, wr_cnt};
        err   = write_q;
      end
      hit_tx:   err = !write_q || (full && !pop) || !strb_q[0];
      hit_lvl:  begin
        rdata = lvl32;
        err   = write_q;
      end
      default:  err = 1'b1;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (load) state_nx = SETUP;
      SETUP, ACCESS: begin
        unique case (1'b1)
          !PSEL:   state_nx = IDLE;
          load:    state_nx = SETUP;
          done:    state_nx = IDLE;
          default: state_nx = ACCESS;
        endcase
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      addr_q  <= PADDR;
      wdata_q <= PWDATA;
      write_q <= PWRITE;
      cnt_q   <= ctrl_q.wait_cnt;
    end else if (step && cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

`ifdef APB_PSTRB_EN
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)    strb_q <= '0;
    else if (load) strb_q <= PSTRB;
  end
`else
  assign strb_q = 4'hF;
`endif

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_q    <= CTRL_RST;
      scratch_q <= SCRATCH_RST;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      irq       <= 1'b0;
    end else begin
      irq <= ctrl_q.ie && empty;
      if (commit) begin
        if (write_q) wr_cnt <= wr_cnt + 16'd1;
        else         rd_cnt <= rd_cnt + 16'd1;
        if (write_q && hit_ctrl) ctrl_q <= ctrl_t'(merged[4:0]);
        if (write_q && hit_scr)  scratch_q <= merged;
      end
    end
  end

  apb_uart_txfifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_txfifo (
    .clk   (PCLK),
    .rst   (PRESET),
    .push  (push),
    .din   (wdata_q[7:0]),
    .pop   (pop),
    .dout  (tx_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

endmodule

// File: tb/tb_apb_uart_completer.sv
// Bench for apb_uart_completer: vector table through an APB driver,
// scoreboards for completions and TX bytes, plus irq/reset sequences.
module tb_apb_uart_completer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, irq;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       nm;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    logic        er;
    int          cyc;
  } vec_t;

  typedef struct {
    string       nm;
    logic [31:0] rd;
    logic        er;
    logic        chk_rd;
  } exp_t;

  vec_t       v[$];
  exp_t       sb[$];
  logic [7:0] tx_exp[$];

  always #5 clk = ~clk;

  apb_uart_completer #(
    .FIFO_DEPTH  (4),
    .RST_WAIT    (0),
    .SCRATCH_RST (32'hA5A5_0000)
  ) dut (
    .PCLK     (clk),
    .PRESET   (rst),
    .PADDR    (paddr),
    .PSEL     (psel),
    .PENABLE  (penable),
    .PWRITE   (pwrite),
    .PWDATA   (pwdata),
    .PRDATA   (prdata),
    .PREADY   (pready),
    .PSLVERR  (pslverr),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .irq      (irq)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] rd, input logic er,
                              input int cyc);
    vec_t r;
    r.nm = nm; r.w = w; r.a = a; r.d = d;
    r.rd = rd; r.er = er; r.cyc = cyc;
    return r;
  endfunction

  always @(negedge clk) begin
    if (psel && penable && pready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_empty: unexpected completion at %h", paddr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.nm, "_err"}, {31'b0, pslverr}, {31'b0, e.er});
        if (e.chk_rd) chk({e.nm, "_rd"}, prdata, e.rd);
      end
    end
  end

  always @(negedge clk) begin
    if (tx_valid && tx_ready) begin
      if (tx_exp.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL tx_extra: got %h want none", tx_data);
      end else begin
        chk("tx_data", {24'b0, tx_data}, {24'b0, tx_exp.pop_front()});
      end
    end
  end

  // Called and returns one time unit after a rising edge.
  task automatic apb(input logic w, input logic [31:0] a,
                     input logic [31:0] d, output int n, output logic to);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    n = 2;
    to = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (pready) begin
        to = 1'b0;
        break;
      end
      chk("wait_prdata", prdata, 32'h0);
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic xfer(input string nm, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] rd,
                      input logic er, input int cyc);
    int   n;
    logic to;
    exp_t e;
    e.nm = nm; e.rd = rd; e.er = er; e.chk_rd = !w && !er;
    sb.push_back(e);
    if (w && a == 32'hC && !er) tx_exp.push_back(d[7:0]);
    apb(w, a, d, n, to);
    if (to) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_timeout: got no PREADY want PREADY", nm);
      void'(sb.pop_back());
    end else begin
      chk({nm, "_cyc"}, n, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    v.push_back(mk("w_scr",   1, 32'h04, 32'hDEADBEEF, 0, 0, 2));
    v.push_back(mk("r_scr",   0, 32'h04, 0, 32'hDEADBEEF, 0, 2));
    v.push_back(mk("r_stat1", 0, 32'h08, 0, 32'h0001_0001, 0, 2));
    v.push_back(mk("r_ctrl0", 0, 32'h00, 0, 32'h0, 0, 2));
    v.push_back(mk("w_ctrl3", 1, 32'h00, 32'h3, 0, 0, 2));
    v.push_back(mk("r_scr_w3", 0, 32'h04, 0, 32'hDEADBEEF, 0, 5));
    v.push_back(mk("w_ctrl0", 1, 32'h00, 32'h0, 0, 0, 5));
    v.push_back(mk("r_ctrl", 0, 32'h00, 0, 32'h0, 0, 2));
    v.push_back(mk("tx1", 1, 32'h0C, 32'h11, 0, 0, 2));
    v.push_back(mk("tx2", 1, 32'h0C, 32'h12, 0, 0, 2));
    v.push_back(mk("tx3", 1, 32'h0C, 32'h13, 0, 0, 2));
    v.push_back(mk("tx4", 1, 32'h0C, 32'h14, 0, 0, 2));
    v.push_back(mk("r_lvl4", 0, 32'h10, 0, 32'h4, 0, 2));
    v.push_back(mk("tx5_full", 1, 32'h0C, 32'h15, 0, 1, 2));
    v.push_back(mk("r_txdata", 0, 32'h0C, 0, 0, 1, 2));
    v.push_back(mk("w_stat", 1, 32'h08, 32'h1, 0, 1, 2));
    v.push_back(mk("r_0x20", 0, 32'h20, 0, 0, 1, 2));
    v.push_back(mk("w_0x06", 1, 32'h06, 32'h1, 0, 1, 2));
    v.push_back(mk("w_0x14", 1, 32'h14, 32'h1, 0, 1, 2));
    v.push_back(mk("w_lvl", 1, 32'h10, 32'h1, 0, 1, 2));
    v.push_back(mk("r_stat2", 0, 32'h08, 0, 32'h0006_0007, 0, 2));
    v.push_back(mk("r_scr2", 0, 32'h04, 0, 32'hDEADBEEF, 0, 2));

    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pready", {31'b0, pready}, 32'h0);
    chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
    chk("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, tx_data}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (v[i]) xfer(v[i].nm, v[i].w, v[i].a, v[i].d,
                        v[i].rd, v[i].er, v[i].cyc);

    // irq rises one cycle after the FIFO drains with IE set
    xfer("w_ctrl_ie", 1, 32'h00, 32'h10, 0, 0, 2);
    @(negedge clk);
    chk("irq_full", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!tx_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk("drain_done", {31'b0, found}, 32'h1);
    chk("irq_lag", {31'b0, irq}, 32'h0);
    @(negedge clk);
    chk("irq_rise", {31'b0, irq}, 32'h1);
    @(posedge clk); #1;
    tx_ready = 1'b0;

    // irq falls one cycle after a push
    xfer("tx_irq", 1, 32'h0C, 32'h22, 0, 0, 2);
    @(negedge clk);
    chk("tx_valid_push", {31'b0, tx_valid}, 32'h1);
    chk("irq_lag1", {31'b0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_fall", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;

    // reset in the wait phase of a SCRATCH write
    xfer("w_ctrl3b", 1, 32'h00, 32'h3, 0, 0, 2);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 32'h04; pwdata = 32'h1234_5678;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    chk("rst_wait_pready", {31'b0, pready}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_pready", {31'b0, pready}, 32'h0);
    chk("mid_rst_tx_valid", {31'b0, tx_valid}, 32'h0);
    psel = 1'b0; penable = 1'b0;
    tx_exp.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    xfer("post_scr", 0, 32'h04, 0, 32'hA5A5_0000, 0, 2);
    xfer("post_lvl", 0, 32'h10, 0, 32'h0, 0, 2);
    xfer("post_ctrl", 0, 32'h00, 0, 32'h0, 0, 2);
    xfer("post_stat", 0, 32'h08, 0, 32'h0003_0000, 0, 2);

    repeat (2) @(posedge clk);
    chk("sb_left", sb.size(), 32'h0);
    chk("tx_left", tx_exp.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
